// File: rtl/comm_pkg.sv
// Shared types and constants for the PSDU packetizer and its CRC engine.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DROP,
    PHR,
    DATA,
    FCS0,
    FCS1,
    GAP
  } pkt_state_e;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam int unsigned PHR_LEN_W       = 7;
  localparam int unsigned FCS_BYTES       = 2;
  localparam int unsigned BUF_DEPTH       = 128;
  localparam int unsigned PTR_W           = 7;

  // One byte of CRC-16/KERMIT (reflected 0x1021), LSB of the data byte first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC16_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/psdu_crc16.sv
// Byte-wide CRC-16/KERMIT accumulator; clear has priority over en.
module psdu_crc16
  import comm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC: clear to zero, fold in one byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc16_byte(crc_q, data);
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/psdu_packetizer.sv
// Buffers one MAC payload, then emits PHR, payload and FCS bytes paced at
// one strobe per BYTE_PERIOD clocks, followed by an inter-frame gap.
module psdu_packetizer
  import comm_pkg::*;
#(
  parameter int unsigned BYTE_PERIOD = 8,
  parameter int unsigned MAX_PAYLOAD = 125,
  parameter int unsigned IFS_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] mac_data,
  input  logic       mac_valid,
  input  logic       mac_last,
  output logic       mac_ready,
  output logic [7:0] phr_psdu_out,
  output logic       phr_psdu_out_valid,
  output logic       tx_busy,
  output logic       frame_drop
);

  localparam int unsigned GAP_CLKS = IFS_PERIODS * BYTE_PERIOD - 1;
  localparam int unsigned CNT_W    = $clog2(IFS_PERIODS * BYTE_PERIOD + 1);

  pkt_state_e           state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PHR_LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           hold_q;
  logic                 drop_q, drop_d;

  logic                 buf_we;
  logic                 crc_en;
  logic                 crc_clear;
  logic [15:0]          crc;
  logic                 ready_state;
  logic                 strobe;
  logic [7:0]           cur_byte;
  logic [7:0]           buf_mem [BUF_DEPTH];

  psdu_crc16 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .en      (crc_en),
    .data    (mac_data),
    .crc     (crc)
  );

  // Next-state, pointer, length and pacing-counter logic.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    drop_d    = 1'b0;
    buf_we    = 1'b0;
    crc_en    = 1'b0;
    crc_clear = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        cnt_d = '0;
        if (mac_valid) begin
          // Byte MAX_PAYLOAD+1: oversize. If it is also the last byte the
          // frame is discarded at once, otherwise the rest is drained in DROP.
          if (wr_ptr_q == PTR_W'(MAX_PAYLOAD)) begin
            if (mac_last) begin
              drop_d    = 1'b1;
              crc_clear = 1'b1;
              wr_ptr_d  = '0;
              len_d     = '0;
              state_d   = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            buf_we   = 1'b1;
            crc_en   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (mac_last) begin
              len_d    = wr_ptr_q + PTR_W'(1);
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              state_d  = PHR;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      DROP: begin
        cnt_d = '0;
        if (mac_valid && mac_last) begin
          drop_d    = 1'b1;
          crc_clear = 1'b1;
          wr_ptr_d  = '0;
          len_d     = '0;
          state_d   = IDLE;
        end
      end
      PHR: begin
        if (cnt_q == CNT_W'(BYTE_PERIOD - 1)) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(BYTE_PERIOD - 1)) begin
          cnt_d = '0;
          if (rd_ptr_q == len_q - PHR_LEN_W'(1)) begin
            state_d = FCS0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FCS0: begin
        if (cnt_q == CNT_W'(BYTE_PERIOD - 1)) begin
          cnt_d   = '0;
          state_d = FCS1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FCS1: begin
        // FCS1 lives only for its strobe cycle; the gap starts right after.
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
          cnt_d     = '0;
          crc_clear = 1'b1;
          len_d     = '0;
          rd_ptr_d  = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hold_q   <= phr_psdu_out;
      drop_q   <= drop_d;
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr_q] <= mac_data;
    end
  end

  // Byte presented on the current strobe, selected by the transmit state.
  always_comb begin
    cur_byte = hold_q;
    case (state_q)
      PHR:     cur_byte = {1'b0, len_q + PHR_LEN_W'(FCS_BYTES)};
      DATA:    cur_byte = buf_mem[rd_ptr_q];
      FCS0:    cur_byte = crc[7:0];
      FCS1:    cur_byte = crc[15:8];
      default: cur_byte = hold_q;
    endcase
  end

  assign ready_state        = (state_q == IDLE) || (state_q == LOAD) || (state_q == DROP);
  // Gated by reset_n so the upstream sees no readiness while reset is held.
  assign mac_ready          = reset_n && ready_state;
  assign strobe             = (cnt_q == '0) &&
                              ((state_q == PHR) || (state_q == DATA) ||
                               (state_q == FCS0) || (state_q == FCS1));
  assign phr_psdu_out_valid = strobe;
  assign phr_psdu_out       = strobe ? cur_byte : hold_q;
  assign tx_busy            = (state_q == PHR) || (state_q == DATA) || (state_q == FCS0) ||
                              (state_q == FCS1) || (state_q == GAP);
  assign frame_drop         = drop_q;

endmodule

// File: tb/tb_psdu_packetizer.sv
// Directed bench for psdu_packetizer: frame contents, strobe pacing, gap,
// oversize drop, mid-frame reset and a maximum-length frame.
module tb_psdu_packetizer;

  localparam int unsigned P = 8;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] mac_data = '0;
  logic       mac_valid = 1'b0;
  logic       mac_last = 1'b0;
  logic       mac_ready;
  logic [7:0] phr_psdu_out;
  logic       phr_psdu_out_valid;
  logic       tx_busy;
  logic       frame_drop;

  psdu_packetizer #(
    .BYTE_PERIOD (8),
    .MAX_PAYLOAD (125),
    .IFS_PERIODS (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .mac_data           (mac_data),
    .mac_valid          (mac_valid),
    .mac_last           (mac_last),
    .mac_ready          (mac_ready),
    .phr_psdu_out       (phr_psdu_out),
    .phr_psdu_out_valid (phr_psdu_out_valid),
    .tx_busy            (tx_busy),
    .frame_drop         (frame_drop)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and drop monitor, sampled on the falling edge.
  logic [7:0]  sb_byte[$];
  int unsigned sb_cyc[$];
  int unsigned drop_cnt = 0;
  always @(negedge clk) begin
    if (phr_psdu_out_valid) begin
      sb_byte.push_back(phr_psdu_out);
      sb_cyc.push_back(cyc);
    end
    if (frame_drop) drop_cnt <= drop_cnt + 1;
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // CRC-16/KERMIT reference: MSB-first CCITT on bit-reversed bytes, result reversed.
  function automatic logic [15:0] crc_model(input bq_t pl);
    logic [15:0] c;
    logic [7:0]  r;
    logic [15:0] o;
    c = '0;
    foreach (pl[i]) begin
      for (int j = 0; j < 8; j++) r[j] = pl[i][7-j];
      c = c ^ {r, 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    for (int j = 0; j < 16; j++) o[j] = c[15-j];
    return o;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last,
                           output int unsigned acc, output int unsigned stalls);
    mac_data  = d;
    mac_last  = last;
    mac_valid = 1'b1;
    stalls    = 0;
    forever begin
      @(negedge clk);
      if (mac_ready) break;
      stalls++;
      if (stalls > 3000) begin
        chk("accept_timeout", {31'd0, mac_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc       = cyc;
    mac_valid = 1'b0;
    mac_last  = 1'b0;
  endtask

  task automatic send_frame(input bq_t pl, output int unsigned acc, output int unsigned stalls);
    int unsigned s;
    stalls = 0;
    foreach (pl[i]) begin
      send_byte(pl[i], (i == pl.size() - 1), acc, s);
      if (i != 0) stalls += s;
    end
  endtask

  task automatic wait_strobes(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (sb_byte.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_count"}, sb_byte.size(), target);
  endtask

  task automatic check_frame(input string tag, input bq_t pl, input int unsigned base,
                             input int unsigned acc, input logic [15:0] fcs);
    int unsigned n;
    logic [7:0]  e;
    n = pl.size();
    if (sb_byte.size() < base + n + 3) begin
      chk({tag, "_short"}, sb_byte.size(), base + n + 3);
      return;
    end
    for (int unsigned k = 0; k < n + 3; k++) begin
      if (k == 0)          e = {1'b0, 7'(n + 2)};
      else if (k <= n)     e = pl[k-1];
      else if (k == n + 1) e = fcs[7:0];
      else                 e = fcs[15:8];
      chk($sformatf("%s_b%0d", tag, k), sb_byte[base+k], e);
      chk($sformatf("%s_t%0d", tag, k), sb_cyc[base+k], acc + P * k);
    end
  endtask

  initial begin
    bq_t         pl, pl2;
    int unsigned acc, acc2, st, st2, base, base2, d0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, mac_ready}, 32'd0);
    chk("rst_valid", {31'd0, phr_psdu_out_valid}, 32'd0);
    chk("rst_out", {24'd0, phr_psdu_out}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_drop", {31'd0, frame_drop}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, mac_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: "123456789", then 4: second frame offered during transmission
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    base = sb_byte.size();
    send_frame(pl, acc, st);
    chk("t1_stalls", st, 0);
    send_byte(8'hA5, 1'b1, acc2, st2);
    chk("t4_held_off", {31'd0, (st2 != 0)}, 32'd1);
    if (sb_cyc.size() >= base + 12) chk("t4_gap_end", acc2, sb_cyc[base+11] + 33);
    wait_strobes("t4", base + 16, 400);
    check_frame("t1", pl, base, acc, 16'h2189);
    pl2 = '{8'hA5};
    check_frame("t4", pl2, base + 12, acc2, crc_model(pl2));

    // 2: single zero byte
    pl = '{8'h00};
    base = sb_byte.size();
    send_frame(pl, acc, st);
    wait_strobes("t2", base + 4, 200);
    check_frame("t2", pl, base, acc, 16'h0000);
    @(negedge clk);
    chk("t2_gap_busy", {31'd0, tx_busy}, 32'd1);
    chk("t2_gap_ready", {31'd0, mac_ready}, 32'd0);

    // 3: oversize frame dropped, next frame normal
    d0 = drop_cnt;
    base = sb_byte.size();
    st = 0;
    for (int i = 0; i < 126; i++) begin
      send_byte(8'(i), 1'b0, acc, st2);
      if (i != 0) st += st2;
    end
    send_byte(8'h55, 1'b1, acc, st2);
    st += st2;
    chk("t3_stalls", st, 0);
    repeat (5) @(negedge clk);
    chk("t3_drops", drop_cnt - d0, 1);
    chk("t3_nostrobe", sb_byte.size(), base);
    chk("t3_ready", {31'd0, mac_ready}, 32'd1);
    chk("t3_busy", {31'd0, tx_busy}, 32'd0);
    @(posedge clk);
    #1;
    pl = '{8'h12, 8'h34};
    send_frame(pl, acc, st);
    wait_strobes("t3b", base + 5, 200);
    check_frame("t3b", pl, base, acc, crc_model(pl));

    // 5: reset during DATA strobe 3
    pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    base = sb_byte.size();
    send_frame(pl, acc, st);
    wait_strobes("t5_pre", base + 3, 300);
    st = 0;
    forever begin
      @(negedge clk);
      if (phr_psdu_out_valid) break;
      st++;
      if (st > 50) break;
    end
    chk("t5_at_strobe", {31'd0, phr_psdu_out_valid}, 32'd1);
    chk("t5_strobe_byte", {24'd0, phr_psdu_out}, 32'h0000_00C3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, phr_psdu_out_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("t5_rst_ready", {31'd0, mac_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t5_rel_ready", {31'd0, mac_ready}, 32'd1);
    chk("t5_rel_busy", {31'd0, tx_busy}, 32'd0);
    repeat (100) @(posedge clk);
    chk("t5_no_more", sb_byte.size(), base + 4);
    #1;

    // 6: maximum frame of 0xFF
    pl = {};
    for (int i = 0; i < 125; i++) pl.push_back(8'hFF);
    base = sb_byte.size();
    send_frame(pl, acc, st);
    chk("t6_stalls", st, 0);
    wait_strobes("t6", base + 128, 1300);
    if (sb_byte.size() > base) chk("t6_phr", {24'd0, sb_byte[base]}, 32'h0000_007F);
    check_frame("t6", pl, base, acc, crc_model(pl));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
